// File: rtl/sdram_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pattern_tester
// Brief    : Fills an SDRAM address range with a selectable pattern, reads it
//            back and reports pass flag, saturating error count, first error.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_pattern_tester #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 22,
    parameter int ADDR_LAST = 2**ADDR_W - 1,
    parameter int ERR_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [1:0]        MODE,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [ERR_W-1:0]  ERR_CNT,
    output logic [ADDR_W-1:0] FIRST_ERR_ADDR,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic              MEM_RVALID,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(ADDR_LAST);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_mode;

    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_last;
    logic [DATA_W-1:0]   w_exp_data;
    logic [DATA_W-1:0]   w_next_wdata;
    logic                w_mismatch;

    function automatic logic [DATA_W-1:0] f_pattern(input logic [1:0] mode,
                                                    input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        case (mode)
            2'd0: v = DATA_W'(a);
            2'd1: v = ~DATA_W'(a);
            2'd2: v = DATA_W'(1) << (32'(a) % DATA_W);
            default: begin
                // Even bit positions follow ~a[0], odd ones follow a[0].
                for (int i = 0; i < DATA_W; i++) begin
                    v[i] = (i % 2 == 0) ? ~a[0] : a[0];
                end
            end
        endcase
        return v;
    endfunction

    assign w_next_addr  = r_addr + ADDR_W'(1);
    assign w_last       = (r_addr == c_ADDR_LAST);
    assign w_exp_data   = f_pattern(r_mode, r_addr);
    assign w_next_wdata = f_pattern(r_mode, w_next_addr);
    assign w_mismatch   = (MEM_RDATA != w_exp_data);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_mode         <= 2'd0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
            ERR_CNT        <= '0;
            FIRST_ERR_ADDR <= '0;
            MEM_REQ        <= 1'b0;
            MEM_WE         <= 1'b0;
            MEM_ADDR       <= '0;
            MEM_WDATA      <= '0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    BUSY <= 1'b0;
                    if (START) begin
                        r_mode         <= MODE;
                        r_addr         <= '0;
                        ERR_CNT        <= '0;
                        FIRST_ERR_ADDR <= '0;
                        PASS           <= 1'b0;
                        BUSY           <= 1'b1;
                        MEM_REQ        <= 1'b1;
                        MEM_WE         <= 1'b1;
                        MEM_ADDR       <= '0;
                        MEM_WDATA      <= f_pattern(MODE, '0);
                        r_state        <= S_WR;
                    end
                end
                S_WR: begin
                    if (MEM_ACK) begin
                        if (w_last) begin
                            r_addr    <= '0;
                            MEM_WE    <= 1'b0;
                            MEM_ADDR  <= '0;
                            MEM_WDATA <= '0;
                            r_state   <= S_RD_REQ;
                        end else begin
                            r_addr    <= w_next_addr;
                            MEM_ADDR  <= w_next_addr;
                            MEM_WDATA <= w_next_wdata;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (MEM_ACK) begin
                        MEM_REQ <= 1'b0;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (MEM_RVALID) begin
                        if (w_mismatch) begin
                            if (ERR_CNT != '1) begin
                                ERR_CNT <= ERR_CNT + ERR_W'(1);
                            end
                            if (ERR_CNT == '0) begin
                                FIRST_ERR_ADDR <= r_addr;
                            end
                        end
                        if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_addr   <= w_next_addr;
                            MEM_REQ  <= 1'b1;
                            MEM_ADDR <= w_next_addr;
                            r_state  <= S_RD_REQ;
                        end
                    end
                end
                S_FIN: begin
                    DONE    <= 1'b1;
                    PASS    <= (ERR_CNT == '0);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
